// File: rtl/key_event_decoder_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key gesture decoder:
//   - one-hot FSM state encodings (IDLE, PRESS1, WAIT2, PRESS2, LONG)
//   - default timing limits for a 50 MHz clock
//   - small helpers used by the decoder
// -----------------------------------------------------------------------------
package key_evt_pkg;

  // One-hot gesture states. Each bit position is owned by exactly one state.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_PRESS1 = 5'b00010,
    ST_WAIT2  = 5'b00100,
    ST_PRESS2 = 5'b01000,
    ST_LONG   = 5'b10000
  } state_e;

  // Default timing at 50 MHz.
  localparam int LONG_CNT_DEF   = 50_000_000;  // 1 s hold for a long press
  localparam int DCLICK_CNT_DEF = 12_500_000;  // 250 ms double-click window
  localparam int REPEAT_CNT_DEF = 10_000_000;  // 200 ms auto-repeat period
  localparam int CNT_W_DEF      = 26;          // 2^26 > 50_000_000

  // True for the states in which the key is considered held down.
  function automatic logic is_pressed_state(input state_e s);
    logic v;
    case (s)
      ST_PRESS1: v = 1'b1;
      ST_PRESS2: v = 1'b1;
      ST_LONG:   v = 1'b1;
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// -----------------------------------------------------------------------------
// key_event_decoder_if
// Bundles the debouncer-side inputs and the gesture pulse outputs.
//   key_flag     : one-cycle debounced edge event   (master -> slave)
//   key_state    : debounced level, 0 = pressed     (master -> slave)
//   short_pulse  : single short press completed     (slave -> master)
//   double_pulse : double click completed           (slave -> master)
//   long_pulse   : long-press threshold reached     (slave -> master)
//   repeat_pulse : auto-repeat tick during long     (slave -> master)
//   key_held     : level, key considered pressed    (slave -> master)
// master = debouncer / consumer side, slave = key_event_decoder.
// -----------------------------------------------------------------------------
interface key_event_decoder_if;
  logic key_flag;
  logic key_state;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  modport master (
    output key_flag,
    output key_state,
    input  short_pulse,
    input  double_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  key_held
  );

  modport slave (
    input  key_flag,
    input  key_state,
    output short_pulse,
    output double_pulse,
    output long_pulse,
    output repeat_pulse,
    output key_held
  );
endinterface

// File: rtl/key_event_decoder_evt_timer.sv
// -----------------------------------------------------------------------------
// evt_timer
// Per-state cycle counter for the gesture FSM. The counter is cleared by the
// FSM whenever the state is about to change (or wraps in LONG), so it reads 0
// in the first cycle of every state. o_hit flags the last cycle of the
// current limit, i.e. cnt == limit - 1.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_clr   : force the counter to 0 at the next edge
//   i_limit : active limit for the current state
//   o_hit   : combinational timeout flag for this cycle
// -----------------------------------------------------------------------------
module evt_timer #(
  parameter int CNT_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  // Last count value before the limit is reached.
  assign w_last = i_limit - {{(CNT_W-1){1'b0}}, 1'b1};
  assign o_hit  = (r_cnt == w_last);

  // Free-running count within a state; cleared on reset or on request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Classifies debounced key gestures into short press, double click and long
// press, and emits auto-repeat ticks while a long press is held. All pulse
// outputs are registered, one cycle wide, and mutually exclusive.
// Ports:
//   i_clk : system clock (50 MHz nominal)
//   i_rst : synchronous active-high reset; discards any gesture in progress
//   bus   : key_event_decoder_if.slave
//           in : key_flag, key_state (0 = pressed)
//           out: short_pulse, double_pulse, long_pulse, repeat_pulse, key_held
// Parameters:
//   LONG_CNT   : cycles a press must be held to count as long
//   DCLICK_CNT : window after a release in which a second press is a double
//   REPEAT_CNT : repeat tick period while in long press
//   CNT_W      : timer width, 2^CNT_W must exceed every limit
// -----------------------------------------------------------------------------
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEF,
  parameter int DCLICK_CNT = DCLICK_CNT_DEF,
  parameter int REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  key_event_decoder_if.slave    bus
);

  localparam logic [CNT_W-1:0] LIM_LONG   = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] LIM_DCLICK = CNT_W'(DCLICK_CNT);
  localparam logic [CNT_W-1:0] LIM_REPEAT = CNT_W'(REPEAT_CNT);

  state_e           r_state;
  state_e           w_next_state;

  logic             w_press_ev;
  logic             w_rel_ev;
  logic             w_hit;
  logic             w_clr;
  logic [CNT_W-1:0] w_limit;

  logic             w_short_nxt;
  logic             w_double_nxt;
  logic             w_long_nxt;
  logic             w_repeat_nxt;
  logic             w_held_nxt;

  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  assign w_press_ev = bus.key_flag & ~bus.key_state;
  assign w_rel_ev   = bus.key_flag &  bus.key_state;

  // Clear the timer whenever the state changes so every state starts at 0.
  // The LONG wrap and IDLE (where the count is meaningless) also clear it,
  // which keeps cnt strictly below the largest limit.
  assign w_clr = (w_next_state != r_state) | w_repeat_nxt | (r_state == ST_IDLE);

  evt_timer #(
    .CNT_W (CNT_W)
  ) u_evt_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  // Select the timeout that applies to the current state.
  always_comb begin
    w_limit = LIM_LONG;
    case (r_state)
      ST_PRESS1: w_limit = LIM_LONG;
      ST_PRESS2: w_limit = LIM_LONG;
      ST_WAIT2:  w_limit = LIM_DCLICK;
      ST_LONG:   w_limit = LIM_REPEAT;
      default:   w_limit = LIM_LONG;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Events take priority over a coinciding timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press_ev) begin
          w_next_state = ST_PRESS1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_PRESS1: begin
        if (w_rel_ev) begin
          w_next_state = ST_WAIT2;
        end else if (w_hit) begin
          w_next_state = ST_LONG;
        end else begin
          w_next_state = ST_PRESS1;
        end
      end
      ST_WAIT2: begin
        if (w_press_ev) begin
          w_next_state = ST_PRESS2;
        end else if (w_hit) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT2;
        end
      end
      ST_PRESS2: begin
        if (w_rel_ev) begin
          w_next_state = ST_IDLE;
        end else if (w_hit) begin
          w_next_state = ST_LONG;
        end else begin
          w_next_state = ST_PRESS2;
        end
      end
      ST_LONG: begin
        if (w_rel_ev) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_LONG;
        end
      end
      default: begin
        // Any corrupted encoding recovers to IDLE.
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode: pulse requests for the next cycle. At most one is set
  // because each is tied to a distinct state/branch.
  always_comb begin
    w_short_nxt  = 1'b0;
    w_double_nxt = 1'b0;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      ST_PRESS1: begin
        if (!w_rel_ev && w_hit) begin
          w_long_nxt = 1'b1;
        end else begin
          w_long_nxt = 1'b0;
        end
      end
      ST_WAIT2: begin
        if (!w_press_ev && w_hit) begin
          w_short_nxt = 1'b1;
        end else begin
          w_short_nxt = 1'b0;
        end
      end
      ST_PRESS2: begin
        // A long hold after the second press cancels the double click.
        if (w_rel_ev) begin
          w_double_nxt = 1'b1;
        end else if (w_hit) begin
          w_long_nxt = 1'b1;
        end else begin
          w_double_nxt = 1'b0;
        end
      end
      ST_LONG: begin
        if (!w_rel_ev && w_hit) begin
          w_repeat_nxt = 1'b1;
        end else begin
          w_repeat_nxt = 1'b0;
        end
      end
      default: begin
        w_short_nxt = 1'b0;
      end
    endcase
    w_held_nxt = is_pressed_state(w_next_state);
  end

  // Output registers: pulses and key_held appear one cycle after the cause.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_short  <= w_short_nxt;
      r_double <= w_double_nxt;
      r_long   <= w_long_nxt;
      r_repeat <= w_repeat_nxt;
      r_held   <= w_held_nxt;
    end
  end

  assign bus.short_pulse  = r_short;
  assign bus.double_pulse = r_double;
  assign bus.long_pulse   = r_long;
  assign bus.repeat_pulse = r_repeat;
  assign bus.key_held     = r_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_decoder
// Scoreboard bench: each stimulus step pushes the pulses it must cause, with
// the cycle they must appear in, and a negedge monitor pops and compares.
// Timing used: LONG=100, DCLICK=40, REPEAT=20. An event driven in cycle c is
// sampled at the end of cycle c; a timeout in cycle c pulses in cycle c+1.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int LONG_N = 100;
  localparam int DCLK_N = 40;
  localparam int REP_N  = 20;

  localparam logic [3:0] K_SHORT  = 4'b1000;
  localparam logic [3:0] K_DOUBLE = 4'b0100;
  localparam logic [3:0] K_LONG   = 4'b0010;
  localparam logic [3:0] K_REPEAT = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  key_event_decoder_if bus ();

  key_event_decoder #(
    .LONG_CNT   (LONG_N),
    .DCLICK_CNT (DCLK_N),
    .REPEAT_CNT (REP_N),
    .CNT_W      (8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [3:0] k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle debounced event; pressed=1 gives press_ev, 0 gives rel_ev.
  task automatic ev(input logic pressed);
    bus.key_flag  = 1'b1;
    bus.key_state = ~pressed;
    tick();
    bus.key_flag  = 1'b0;
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    logic [3:0] obs;
    logic [3:0] expv;
    obs  = {bus.short_pulse, bus.double_pulse, bus.long_pulse, bus.repeat_pulse};
    expv = 4'b0000;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      expv = q[0].kind;
      void'(q.pop_front());
    end
    if (obs != 4'b0000 || expv != 4'b0000) chk("pulse", {28'd0, obs}, {28'd0, expv});
  end

  initial begin
    int p;
    int r;
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    idle(3);
    chk("rst_outs", {27'd0, bus.short_pulse, bus.double_pulse, bus.long_pulse,
                     bus.repeat_pulse, bus.key_held}, 32'd0);
    rst = 1'b0;
    idle(3);

    // Test 1: short press.
    p = cyc;
    ev(1'b1);
    chk("t1_held_rise", {31'd0, bus.key_held}, 32'd1);
    idle(9);
    chk("t1_held_last", {31'd0, bus.key_held}, 32'd1);
    r = cyc;
    push(r + DCLK_N + 1, K_SHORT);
    ev(1'b0);
    chk("t1_held_fall", {31'd0, bus.key_held}, 32'd0);
    idle(60);

    // Test 2: double click.
    ev(1'b1);
    idle(9);
    ev(1'b0);
    idle(14);
    ev(1'b1);
    idle(9);
    r = cyc;
    push(r + 1, K_DOUBLE);
    ev(1'b0);
    idle(60);

    // Test 3: long press with two repeat ticks, silent release.
    p = cyc;
    push(p + LONG_N + 1, K_LONG);
    push(p + LONG_N + 1 + REP_N, K_REPEAT);
    push(p + LONG_N + 1 + 2 * REP_N, K_REPEAT);
    ev(1'b1);
    idle(149);
    chk("t3_held_long", {31'd0, bus.key_held}, 32'd1);
    ev(1'b0);
    chk("t3_held_fall", {31'd0, bus.key_held}, 32'd0);
    idle(40);

    // Test 4a: second press on the last cycle of the double-click window.
    ev(1'b1);
    idle(9);
    ev(1'b0);
    idle(DCLK_N - 1);
    ev(1'b1);
    chk("t4_held_p2", {31'd0, bus.key_held}, 32'd1);
    idle(5);
    r = cyc;
    push(r + 1, K_DOUBLE);
    ev(1'b0);
    idle(60);

    // Test 4b: release on the last cycle before long-press threshold.
    ev(1'b1);
    idle(LONG_N - 1);
    r = cyc;
    push(r + DCLK_N + 1, K_SHORT);
    ev(1'b0);
    chk("t4_held_rel", {31'd0, bus.key_held}, 32'd0);
    idle(60);

    // Test 5: reset mid-gesture discards it.
    ev(1'b1);
    idle(4);
    rst = 1'b1;
    tick();
    chk("t5_rst_outs", {27'd0, bus.short_pulse, bus.double_pulse, bus.long_pulse,
                        bus.repeat_pulse, bus.key_held}, 32'd0);
    rst = 1'b0;
    idle(2);
    ev(1'b0);
    chk("t5_held_idle", {31'd0, bus.key_held}, 32'd0);
    idle(60);
    ev(1'b1);
    idle(9);
    r = cyc;
    push(r + DCLK_N + 1, K_SHORT);
    ev(1'b0);
    idle(60);

    // Test 6: release in IDLE and extra press in PRESS1 are ignored.
    ev(1'b0);
    idle(5);
    chk("t6_idle_rel", {31'd0, bus.key_held}, 32'd0);
    ev(1'b1);
    idle(2);
    ev(1'b1);
    chk("t6_held_dup", {31'd0, bus.key_held}, 32'd1);
    idle(6);
    r = cyc;
    push(r + DCLK_N + 1, K_SHORT);
    ev(1'b0);
    idle(60);

    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
